seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed 7-segment digits (legal range 1..16).
REQ-002 SHALL have parameter REFRESH_CYCLES, default 100000, clk cycles each digit is driven (legal range >=1).
REQ-003 SHALL have parameter DEAD_CYCLES, default 16, anti-ghosting blank cycles between digits (legal range >=0).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = s7 and an asserted low, 0 = asserted high.
REQ-005 SHALL define AW = max(1, clog2(N_DIGITS)).
REQ-006 SHALL provide a single clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 wr_en  input  1  write one digit into the shadow buffer.
REQ-010 wr_addr  input  AW  digit index to write.
REQ-011 wr_data  input  8  bit7 = dp, bits6:0 = segments g..a (raw mode) or bits3:0 = nibble (hex mode).
REQ-012 wr_hex  input  1  1 = decode wr_data[3:0] to a hex glyph, dp taken from wr_data[7].
REQ-013 commit  input  1  request copy of shadow buffer to active buffer.
REQ-014 blank_mask  input  N_DIGITS  bit i = 1 keeps digit i anode inactive.
REQ-015 s7  output  8  segment/dp drive, registered, polarity per ACTIVE_LOW.
REQ-016 an  output  N_DIGITS  one-hot anode drive, registered, polarity per ACTIVE_LOW.
REQ-017 digit_idx  output  AW  index of digit currently scanned.
REQ-018 frame_done  output  1  one-cycle pulse on scan wrap N_DIGITS-1 -> 0.

Function
REQ-019 Write: wr_en=1 with wr_addr < N_DIGITS SHALL update shadow[wr_addr] next edge; wr_addr >= N_DIGITS SHALL be ignored.
REQ-020 Hex glyphs (bit0=a) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-021 commit=1 SHALL set a pending flag; the flag SHALL be held until the next scan wrap.
REQ-022 On the wrap edge, if pending or commit is 1, all active[] SHALL load from shadow[] in that single cycle and pending SHALL clear.
REQ-023 Write and copy on the same edge: copy SHALL take the pre-write shadow value; the write lands in shadow only.
REQ-024 FSM states SHOW and DEAD; SHOW lasts REFRESH_CYCLES cycles, then DEAD lasts DEAD_CYCLES cycles, then digit_idx increments modulo N_DIGITS and SHOW re-enters.
REQ-025 DEAD_CYCLES=0 SHALL skip DEAD; SHOW of the next digit follows directly.
REQ-026 In SHOW: an SHALL assert only bit digit_idx (unless blank_mask[digit_idx]=1) and s7 SHALL carry active[digit_idx].
REQ-027 In DEAD, or when blanked: all an and all s7 bits SHALL be inactive.
REQ-028 s7/an SHALL be registered: one-cycle latency from FSM state/index to pins.
REQ-029 Frame period SHALL be exactly N_DIGITS*(REFRESH_CYCLES+DEAD_CYCLES) cycles, independent of blank_mask, writes or commit.
REQ-030 frame_done SHALL pulse high for exactly one cycle, on the edge digit_idx goes N_DIGITS-1 -> 0; with N_DIGITS=1 it pulses every period.
REQ-031 Inactive level SHALL be 1 when ACTIVE_LOW=1, else 0.

Reset
REQ-032 While rst=1: s7 and an SHALL be inactive immediately (asynchronous), digit_idx=0, frame_done=0, state SHOW, cycle counter 0, pending 0, shadow[] and active[] all 8'h00.
REQ-033 Reset mid-scan SHALL discard any pending commit; first cycle after release SHALL start SHOW of digit 0 with a full REFRESH_CYCLES count.

Verification (N_DIGITS=4, REFRESH_CYCLES=4, DEAD_CYCLES=2, ACTIVE_LOW=1)
REQ-034 Reset: rst=1 -> an=4'hF, s7=8'hFF, digit_idx=0, frame_done=0; release -> first frame_done 24 cycles later, then every 24 cycles.
REQ-035 Hex path: wr_en, wr_hex, wr_addr=2, wr_data=8'h8A, commit -> after next frame_done, during digit 2 SHOW: an=4'b1011, s7=8'h08 (~8'hF7).
REQ-036 Tear-free commit: commit while digit_idx=1 -> digits 1..3 still show old data this frame; new data first visible at digit 0 after frame_done.
REQ-037 Dead time: after 4 SHOW cycles of digit 0 -> 2 cycles an=4'hF, s7=8'hFF, then digit 1 SHOW with an=4'b1101.
REQ-038 Blanking: blank_mask=4'b0010 -> an=4'hF throughout digit 1 slot, frame_done period still 24 cycles.
REQ-039 Mid-scan reset: rst pulse during digit 3 SHOW with pending commit -> outputs inactive same cycle, active[] stays 8'h00 after release, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with shadow/active buffers and dead time
module seg7_scan_driver #(
   parameter int N_DIGITS       = 8,
   parameter int REFRESH_CYCLES = 100000,
   parameter int DEAD_CYCLES    = 16,
   parameter int ACTIVE_LOW     = 1,
   localparam int AW            = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [7:0]          wr_data,
   input  logic                wr_hex,
   input  logic                commit,
   input  logic [N_DIGITS-1:0] blank_mask,
   output logic [7:0]          s7,
   output logic [N_DIGITS-1:0] an,
   output logic [AW-1:0]       digit_idx,
   output logic                frame_done
);

   localparam int   CMAX  = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
   localparam int   CW    = $clog2(CMAX + 1);
   localparam logic INACT = 1'(ACTIVE_LOW != 0);

   typedef enum logic {SHOW, DEAD} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                frame_done_q;
   logic                pending_q, pending_d;
   logic                advance, wrap, copy;
   logic                wr_ok;
   logic [7:0]          wr_val;
   logic [7:0]          s7_q, s7_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [7:0]          shadow_q [N_DIGITS];
   logic [7:0]          active_q [N_DIGITS];

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h3F;
         4'h1: hex_glyph = 7'h06;
         4'h2: hex_glyph = 7'h5B;
         4'h3: hex_glyph = 7'h4F;
         4'h4: hex_glyph = 7'h66;
         4'h5: hex_glyph = 7'h6D;
         4'h6: hex_glyph = 7'h7D;
         4'h7: hex_glyph = 7'h07;
         4'h8: hex_glyph = 7'h7F;
         4'h9: hex_glyph = 7'h6F;
         4'hA: hex_glyph = 7'h77;
         4'hB: hex_glyph = 7'h7C;
         4'hC: hex_glyph = 7'h39;
         4'hD: hex_glyph = 7'h5E;
         4'hE: hex_glyph = 7'h79;
         default: hex_glyph = 7'h71;
      endcase
   endfunction

   // Next-state for the SHOW/DEAD scan, commit bookkeeping and the pin values for the next cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      advance   = 1'b0;
      pending_d = pending_q;
      s7_d      = {8{INACT}};
      an_d      = {N_DIGITS{INACT}};
      case (state_q)
         SHOW: begin
            if (cnt_q == CW'(REFRESH_CYCLES - 1)) begin
               cnt_d = '0;
               if (DEAD_CYCLES == 0) advance = 1'b1;
               else                  state_d = DEAD;
            end
            if (!blank_mask[idx_q]) begin
               an_d = (N_DIGITS'(1) << idx_q) ^ {N_DIGITS{INACT}};
               s7_d = active_q[idx_q] ^ {8{INACT}};
            end
         end
         default: begin
            if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
               cnt_d   = '0;
               advance = 1'b1;
               state_d = SHOW;
            end
         end
      endcase
      wrap = advance && (idx_q == AW'(N_DIGITS - 1));
      if (advance) idx_d = wrap ? '0 : idx_q + 1'b1;
      copy = wrap && (pending_q || commit);
      if (wrap)        pending_d = 1'b0;
      else if (commit) pending_d = 1'b1;
   end

   // Scan state, registered pins and frame pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SHOW;
         cnt_q        <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         pending_q    <= 1'b0;
         s7_q         <= {8{INACT}};
         an_q         <= {N_DIGITS{INACT}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_done_q <= wrap;
         pending_q    <= pending_d;
         s7_q         <= s7_d;
         an_q         <= an_d;
      end
   end

   assign wr_ok  = wr_en && (32'(wr_addr) < 32'(N_DIGITS));
   assign wr_val = wr_hex ? {wr_data[7], hex_glyph(wr_data[3:0])} : wr_data;

   // Shadow takes CPU writes; active reloads from the pre-write shadow only at a frame wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow_q[i] <= 8'h00;
            active_q[i] <= 8'h00;
         end
      end else begin
         if (copy) begin
            for (int i = 0; i < N_DIGITS; i++) active_q[i] <= shadow_q[i];
         end
         if (wr_ok) shadow_q[wr_addr] <= wr_val;
      end
   end

   assign s7         = s7_q;
   assign an         = an_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
   localparam int N  = 4;
   localparam int R  = 4;
   localparam int D  = 2;
   localparam int SL = R + D;
   localparam int FP = N * SL;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_hex = 1'b0;
   logic       commit = 1'b0;
   logic [3:0] blank_mask = '0;
   logic [7:0] s7;
   logic [3:0] an;
   logic [1:0] digit_idx;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(
      .N_DIGITS(N), .REFRESH_CYCLES(R), .DEAD_CYCLES(D), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_hex(wr_hex), .commit(commit), .blank_mask(blank_mask),
      .s7(s7), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: position in the frame is derived from the cycle count since reset
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int         c_m = 0;
   int         m_s, m_d, m_ph;
   logic [7:0] sh_m [N];
   logic [7:0] ac_m [N];
   bit         pend_m = 0;
   logic [7:0] exp_s7 = 8'hFF;
   logic [3:0] exp_an = 4'hF;
   logic [1:0] exp_idx = '0;
   logic       exp_fd = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_m = 0; pend_m = 0;
         for (int i = 0; i < N; i++) begin sh_m[i] = 8'h00; ac_m[i] = 8'h00; end
         exp_s7 = 8'hFF; exp_an = 4'hF; exp_idx = '0; exp_fd = 1'b0;
      end else begin
         m_s = c_m % FP; m_d = m_s / SL; m_ph = m_s % SL;
         if (m_ph < R && !blank_mask[m_d]) begin
            exp_an = ~(4'b0001 << m_d);
            exp_s7 = ~ac_m[m_d];
         end else begin
            exp_an = 4'hF;
            exp_s7 = 8'hFF;
         end
         c_m++;
         exp_idx = 2'((c_m % FP) / SL);
         exp_fd  = ((c_m % FP) == 0);
         if (exp_fd) begin
            if (pend_m || commit) for (int i = 0; i < N; i++) ac_m[i] = sh_m[i];
            pend_m = 0;
         end else if (commit) pend_m = 1;
         if (wr_en) sh_m[wr_addr] = wr_hex ? {wr_data[7], glyph[wr_data[3:0]]} : wr_data;
      end
   end

   task automatic wait_idx_enter(input int d);
      int n = 0;
      while (digit_idx === 2'(d) && n < 200) begin @(negedge clk); n++; end
      while (digit_idx !== 2'(d) && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (digit_idx !== 2'(d)) begin
         errors++;
         $display("FAIL wait_idx: digit_idx=%0d required=%0d", digit_idx, d);
      end
   endtask

   task automatic wait_fd();
      int n = 0;
      do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL wait_frame_done: frame_done=%b required=1", frame_done);
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      @(negedge clk);
      checks += 4;
      if (an !== 4'hF)        begin errors++; $display("FAIL reset_an: an=%h required=f", an); end
      if (s7 !== 8'hFF)       begin errors++; $display("FAIL reset_s7: s7=%h required=ff", s7); end
      if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: idx=%0d required=0", digit_idx); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: fd=%b required=0", frame_done); end
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 40);
         checks++;
         if (n !== FP) begin errors++; $display("FAIL frame_period_%0d: cycles=%0d required=%0d", k, n, FP); end
      end
   endtask

   task automatic test_dead_time();
      logic [3:0] an_exp [8] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks += 2;
         if (an !== an_exp[k]) begin errors++; $display("FAIL dead_an_%0d: an=%h required=%h", k + 1, an, an_exp[k]); end
         if (s7 !== 8'hFF)     begin errors++; $display("FAIL dead_s7_%0d: s7=%h required=ff", k + 1, s7); end
      end
   endtask

   task automatic test_hex();
      wr_en = 1'b1; wr_hex = 1'b1; wr_addr = 2'd2; wr_data = 8'h8A; commit = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; wr_hex = 1'b0; commit = 1'b0;
      wait_fd();
      wait_idx_enter(2);
      @(negedge clk);
      checks += 2;
      if (an !== 4'b1011) begin errors++; $display("FAIL hex_an: an=%b required=1011", an); end
      if (s7 !== 8'h08)   begin errors++; $display("FAIL hex_s7: s7=%h required=08", s7); end
   endtask

   task automatic test_tear_free();
      logic [7:0] old_s7 [4] = '{8'hFF, 8'hFF, 8'h08, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_hex = 1'b0; wr_addr = 2'(i); wr_data = 8'(8'h11 * (i + 1));
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_idx_enter(1);
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      for (int d = 1; d < 4; d++) begin
         if (d > 1) begin wait_idx_enter(d); @(negedge clk); end
         checks += 2;
         if (an !== ~(4'b0001 << d)) begin errors++; $display("FAIL tear_an_%0d: an=%b", d, an); end
         if (s7 !== old_s7[d]) begin errors++; $display("FAIL tear_old_%0d: s7=%h required=%h", d, s7, old_s7[d]); end
      end
      wait_fd();
      @(negedge clk);
      checks += 2;
      if (an !== 4'hE)  begin errors++; $display("FAIL tear_new_an: an=%h required=e", an); end
      if (s7 !== 8'hEE) begin errors++; $display("FAIL tear_new_s7: s7=%h required=ee", s7); end
   endtask

   task automatic test_blank();
      int bad = 0;
      int fd_at = 0;
      wait_fd();
      blank_mask = 4'b0010;
      for (int k = 1; k <= FP; k++) begin
         @(negedge clk);
         if (an[1] !== 1'b1) bad++;
         if (k > SL && k <= 2 * SL && an !== 4'hF) bad++;
         if (frame_done === 1'b1) fd_at = k;
      end
      blank_mask = 4'b0000;
      checks += 2;
      if (bad != 0)   begin errors++; $display("FAIL blank_slot: violations=%0d required=0", bad); end
      if (fd_at != FP) begin errors++; $display("FAIL blank_period: frame_done at=%0d required=%0d", fd_at, FP); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         checks += 4;
         if (s7 !== exp_s7)       begin errors++; $display("FAIL rand_s7 @%0d: s7=%h required=%h", k, s7, exp_s7); end
         if (an !== exp_an)       begin errors++; $display("FAIL rand_an @%0d: an=%h required=%h", k, an, exp_an); end
         if (digit_idx !== exp_idx) begin errors++; $display("FAIL rand_idx @%0d: idx=%0d required=%0d", k, digit_idx, exp_idx); end
         if (frame_done !== exp_fd) begin errors++; $display("FAIL rand_fd @%0d: fd=%b required=%b", k, frame_done, exp_fd); end
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 8'($urandom);
         wr_hex  = ($urandom_range(0, 1) == 1);
         commit  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
      end
      wr_en = 1'b0; commit = 1'b0; blank_mask = 4'b0000;
   endtask

   task automatic test_midscan_reset();
      wait_idx_enter(3);
      @(negedge clk);
      wr_en = 1'b1; wr_hex = 1'b0; wr_addr = 2'd0; wr_data = 8'h5A; commit = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; commit = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks += 4;
      if (an !== 4'hF)         begin errors++; $display("FAIL mrst_an: an=%h required=f", an); end
      if (s7 !== 8'hFF)        begin errors++; $display("FAIL mrst_s7: s7=%h required=ff", s7); end
      if (digit_idx !== 2'd0)  begin errors++; $display("FAIL mrst_idx: idx=%0d required=0", digit_idx); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL mrst_fd: fd=%b required=0", frame_done); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks += 3;
      if (digit_idx !== 2'd0) begin errors++; $display("FAIL mrst_restart_idx: idx=%0d required=0", digit_idx); end
      if (an !== 4'hE)        begin errors++; $display("FAIL mrst_restart_an: an=%h required=e", an); end
      if (s7 !== 8'hFF)       begin errors++; $display("FAIL mrst_restart_s7: s7=%h required=ff", s7); end
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h5A;
      @(negedge clk);
      wr_en = 1'b0;
      wait_fd();
      @(negedge clk);
      checks += 2;
      if (an !== 4'hE)  begin errors++; $display("FAIL mrst_after_an: an=%h required=e", an); end
      if (s7 !== 8'hFF) begin errors++; $display("FAIL mrst_after_s7: s7=%h required=ff", s7); end
   endtask

   initial begin
      test_reset();
      test_dead_time();
      test_hex();
      test_tear_free();
      test_blank();
      test_random();
      test_midscan_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
